// File: rtl/toaplan2_snd_mixer.sv
// toaplan2_snd_mixer: time-multiplexed NCH-channel stereo mixer with 4.4 gains,
// per-channel L/R routing, a mute fade ramp and a stretched clip flag.
// Ports: CLK96/RESET96 clock and async active-high reset; cen sample strobe;
//   ch_in/gain/pan packed per-channel controls; mute fade request;
//   left/right clamped outputs; sample update pulse; peak clip flag; busy mix flag.
// Latency: cen in cycle t -> sample pulse in cycle t+NCH+3. cen while busy is dropped.
module toaplan2_snd_mixer #(
  parameter int NCH       = 4,
  parameter int W         = 16,
  parameter int WOUT      = 16,
  parameter int PEAK_HOLD = 4800000,
  parameter int RAMP_STEP = 1
) (
  input  logic                   CLK96,
  input  logic                   RESET96,
  input  logic                   cen,
  input  logic [NCH*W-1:0]       ch_in,
  input  logic [NCH*8-1:0]       gain,
  input  logic [NCH*2-1:0]       pan,
  input  logic                   mute,
  output logic signed [WOUT-1:0] left,
  output logic signed [WOUT-1:0] right,
  output logic                   sample,
  output logic                   peak,
  output logic                   busy
);

  localparam int CL  = $clog2(NCH);
  localparam int PW  = W + 9;          // product width
  localparam int AW  = PW + CL;        // accumulator width
  localparam int SW  = AW + 10;        // scaled width (acc * 10-bit signed ramp)
  localparam int PCW = $clog2(PEAK_HOLD + 1);
  localparam logic [9:0] STEP = 10'(RAMP_STEP);
  localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (WOUT - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

  // The snapshot is taken on the edge leaving IDLE, so the first ACC cycle
  // already works on shadowed inputs.
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SCALE, S_OUT} state_t;

  state_t                 r_state, w_next;
  logic [NCH*W-1:0]       r_ch_sh;
  logic [NCH*8-1:0]       r_gain_sh;
  logic [NCH*2-1:0]       r_pan_sh;
  logic [CL-1:0]          r_idx;
  logic signed [AW-1:0]   r_acc_l, r_acc_r;
  logic signed [SW-1:0]   r_sc_l, r_sc_r;
  logic [8:0]             r_ramp;
  logic [PCW-1:0]         r_pk;
  logic signed [WOUT-1:0] r_left, r_right;
  logic                   r_sample;

  logic signed [W-1:0]    w_ch;
  logic [7:0]             w_gain;
  logic [1:0]             w_pan;
  logic signed [PW-1:0]   w_chx, w_gx, w_prod;
  logic signed [AW-1:0]   w_prod_ext, w_sh_l, w_sh_r;
  logic signed [SW-1:0]   w_rampx, w_mul_l, w_mul_r;
  logic                   w_hi_l, w_lo_l, w_hi_r, w_lo_r, w_clip;
  logic signed [WOUT-1:0] w_out_l, w_out_r;
  logic [9:0]             w_ramp10;
  logic [8:0]             w_ramp_nxt;
  logic                   w_snap;

  assign w_snap = (r_state == S_IDLE) && cen;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cen) w_next = S_ACC;
      S_ACC:   if (r_idx == CL'(NCH - 1)) w_next = S_SCALE;
      S_SCALE: w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Channel datapath: both operands widened to PW so the product is exact.
  assign w_ch       = r_ch_sh[int'(r_idx)*W +: W];
  assign w_gain     = r_gain_sh[int'(r_idx)*8 +: 8];
  assign w_pan      = r_pan_sh[int'(r_idx)*2 +: 2];
  assign w_chx      = {{9{w_ch[W-1]}}, w_ch};
  assign w_gx       = {{(PW-8){1'b0}}, w_gain};
  assign w_prod     = w_chx * w_gx;
  assign w_prod_ext = {{CL{w_prod[PW-1]}}, w_prod};

  // Scale: drop the 4.4 fraction, then apply the 0..256 ramp (256 = unity).
  assign w_sh_l  = r_acc_l >>> 4;
  assign w_sh_r  = r_acc_r >>> 4;
  assign w_rampx = {{(SW-9){1'b0}}, r_ramp};
  assign w_mul_l = {{10{w_sh_l[AW-1]}}, w_sh_l} * w_rampx;
  assign w_mul_r = {{10{w_sh_r[AW-1]}}, w_sh_r} * w_rampx;

  assign w_hi_l  = r_sc_l > MAXV;
  assign w_lo_l  = r_sc_l < MINV;
  assign w_hi_r  = r_sc_r > MAXV;
  assign w_lo_r  = r_sc_r < MINV;
  assign w_clip  = w_hi_l | w_lo_l | w_hi_r | w_lo_r;
  assign w_out_l = w_hi_l ? MAXV[WOUT-1:0] : (w_lo_l ? MINV[WOUT-1:0] : r_sc_l[WOUT-1:0]);
  assign w_out_r = w_hi_r ? MAXV[WOUT-1:0] : (w_lo_r ? MINV[WOUT-1:0] : r_sc_r[WOUT-1:0]);

  always_comb begin
    w_ramp10   = {1'b0, r_ramp};
    w_ramp_nxt = r_ramp;
    if (mute) w_ramp_nxt = (w_ramp10 > STEP) ? 9'(w_ramp10 - STEP) : 9'd0;
    else      w_ramp_nxt = (w_ramp10 + STEP > 10'd256) ? 9'd256 : 9'(w_ramp10 + STEP);
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_state   <= S_IDLE;
      r_ch_sh   <= '0;
      r_gain_sh <= '0;
      r_pan_sh  <= '0;
      r_idx     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_sc_l    <= '0;
      r_sc_r    <= '0;
      r_ramp    <= '0;
      r_pk      <= '0;
      r_left    <= '0;
      r_right   <= '0;
      r_sample  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_sample <= (r_state == S_OUT);
      if (w_snap) begin
        r_ch_sh   <= ch_in;
        r_gain_sh <= gain;
        r_pan_sh  <= pan;
        r_idx     <= '0;
        r_acc_l   <= '0;
        r_acc_r   <= '0;
      end
      if (r_state == S_ACC) begin
        r_idx <= r_idx + CL'(1);
        if (w_pan[0]) r_acc_l <= r_acc_l + w_prod_ext;
        if (w_pan[1]) r_acc_r <= r_acc_r + w_prod_ext;
      end
      if (r_state == S_SCALE) begin
        r_sc_l <= w_mul_l >>> 8;
        r_sc_r <= w_mul_r >>> 8;
      end
      if (r_state == S_OUT) begin
        r_left  <= w_out_l;
        r_right <= w_out_r;
        r_ramp  <= w_ramp_nxt;
      end
      // A clip reloads the hold counter even while it is still running.
      if ((r_state == S_OUT) && w_clip) r_pk <= PCW'(PEAK_HOLD);
      else if (r_pk != '0)             r_pk <= r_pk - PCW'(1);
    end
  end

  assign left   = r_left;
  assign right  = r_right;
  assign sample = r_sample;
  assign peak   = (r_pk != '0);
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_toaplan2_snd_mixer.sv
// tb_toaplan2_snd_mixer: directed bench for toaplan2_snd_mixer with a
// sample-level reference model checked every cycle plus literal expectations.
// Ports: none (drives CLK96, RESET96, cen, ch_in, gain, pan, mute).
module tb_toaplan2_snd_mixer;
  localparam int NCH = 4, W = 16, WOUT = 16, PH = 40, RS = 1, PER = 16;

  logic CLK96 = 1'b0, RESET96 = 1'b0, cen = 1'b0, mute = 1'b0;
  logic [NCH*W-1:0] ch_in;
  logic [NCH*8-1:0] gain;
  logic [NCH*2-1:0] pan;
  logic signed [WOUT-1:0] left, right;
  logic sample, peak, busy;

  logic signed [W-1:0] tb_ch [NCH];
  logic [7:0]          tb_g  [NCH];
  logic [1:0]          tb_p  [NCH];

  int checks = 0, failures = 0;

  toaplan2_snd_mixer #(.NCH(NCH), .W(W), .WOUT(WOUT), .PEAK_HOLD(PH), .RAMP_STEP(RS)) dut (
    .CLK96(CLK96), .RESET96(RESET96), .cen(cen), .ch_in(ch_in), .gain(gain), .pan(pan),
    .mute(mute), .left(left), .right(right), .sample(sample), .peak(peak), .busy(busy));

  always #5 CLK96 = ~CLK96;

  always_comb begin
    ch_in = '0;
    gain  = '0;
    pan   = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_in[k*W +: W] = tb_ch[k];
      gain[k*8 +: 8]  = tb_g[k];
      pan[k*2 +: 2]   = tb_p[k];
    end
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a mix is captured when cen is seen while idle, and the
  // result appears NCH+3 cycles later, computed straight from the mixing rules.
  longint m_left, m_right, m_sum_l, m_sum_r;
  int     m_ramp, m_phase, m_pk;
  bit     m_sample;

  function automatic longint clampv(input longint v);
    longint hi, lo;
    hi = (64'sd1 <<< (WOUT - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  always @(negedge CLK96) begin
    longint sl, sr;
    if (RESET96) begin
      m_left = 0; m_right = 0; m_sample = 0; m_ramp = 0; m_phase = 0; m_pk = 0;
    end
    chk("left", left, m_left);
    chk("right", right, m_right);
    chk("sample", sample, m_sample);
    chk("busy", busy, m_phase != 0);
    chk("peak", peak, m_pk != 0);
    if (!RESET96) begin
      m_sample = 0;
      if (m_pk > 0) m_pk--;
      if (m_phase == 0) begin
        if (cen) begin
          m_sum_l = 0;
          m_sum_r = 0;
          for (int k = 0; k < NCH; k++) begin
            longint p;
            p = longint'(tb_ch[k]) * longint'(tb_g[k]);
            if (tb_p[k][0]) m_sum_l += p;
            if (tb_p[k][1]) m_sum_r += p;
          end
          m_phase = 1;
        end
      end else if (m_phase == NCH + 2) begin
        sl = ((m_sum_l >>> 4) * m_ramp) >>> 8;
        sr = ((m_sum_r >>> 4) * m_ramp) >>> 8;
        m_left  = clampv(sl);
        m_right = clampv(sr);
        if (m_left != sl || m_right != sr) m_pk = PH;
        m_sample = 1;
        if (mute) m_ramp = (m_ramp > RS) ? m_ramp - RS : 0;
        else      m_ramp = (m_ramp + RS > 256) ? 256 : m_ramp + RS;
        m_phase = 0;
      end else begin
        m_phase++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK96);
    #1;
  endtask

  task automatic do_sample();
    cen = 1'b1;
    tick();
    cen = 1'b0;
    repeat (PER - 1) tick();
  endtask

  task automatic set_ch(input int k, input logic signed [W-1:0] v, input logic [7:0] g, input logic [1:0] p);
    tb_ch[k] = v;
    tb_g[k]  = g;
    tb_p[k]  = p;
  endtask

  initial begin
    int cnt;
    for (int k = 0; k < NCH; k++) set_ch(k, '0, 8'h00, 2'b00);
    #1 RESET96 = 1'b1;
    repeat (4) tick();
    chk("rst_left", left, 0);
    chk("rst_busy", busy, 0);
    chk("rst_peak", peak, 0);
    RESET96 = 1'b0;

    // Fade-in after reset: sample n uses ramp n-1.
    set_ch(0, 16'sd1000, 8'h10, 2'b11);
    for (int n = 1; n <= 260; n++) begin
      do_sample();
      if (n == 1)   chk("fadein_s1", left, 0);
      if (n == 2)   chk("fadein_s2", left, 3);
      if (n == 129) chk("fadein_s129", left, 500);
      if (n == 257) begin chk("fadein_s257_l", left, 1000); chk("fadein_s257_r", right, 1000); end
    end

    // Latency and busy window; second cen at offset 3 is dropped.
    for (int k = 0; k <= 12; k++) begin
      cen = (k == 0 || k == 3);
      tick();
      chk("lat_sample", sample, (k + 1 == NCH + 3));
      chk("lat_busy", busy, (k + 1 >= 1 && k + 1 <= NCH + 2));
    end
    cen = 1'b0;
    repeat (4) tick();

    // Cancellation on left, exact full-scale negative on right; removed channels.
    set_ch(0, 16'sh4000, 8'h20, 2'b01);
    set_ch(1, -16'sh4000, 8'h20, 2'b11);
    set_ch(2, -16'sd5, 8'h10, 2'b00);
    set_ch(3, -16'sd7, 8'h00, 2'b11);
    do_sample();
    chk("cancel_left", left, 0);
    chk("fullneg_right", right, -32768);
    chk("fullneg_peak", peak, 0);

    // Single clip: flag held for exactly PH cycles.
    set_ch(0, 16'sh4000, 8'h21, 2'b11);
    for (int k = 1; k < NCH; k++) set_ch(k, '0, 8'h00, 2'b00);
    cnt = 0;
    for (int k = 0; k < 70; k++) begin
      cen = (k == 0);
      tick();
      cnt += int'(peak);
    end
    cen = 1'b0;
    chk("clip_left", left, 32767);
    chk("clip_right", right, 32767);
    chk("peak_hold_len", cnt, PH);

    // Retrigger mid-hold: flag from cycle 7 through 28+PH-1.
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      cen = (k == 0 || k == 21);
      tick();
      cnt += int'(peak);
    end
    cen = 1'b0;
    chk("peak_retrig_len", cnt, 21 + PH);

    // Snapshot: input changes during accumulation do not leak into the mix.
    set_ch(0, 16'sd1000, 8'h10, 2'b11);
    cen = 1'b1;
    tick();
    cen = 1'b0;
    tb_ch[0] = 16'sd30000;
    tb_g[0]  = 8'hff;
    repeat (3) tick();
    set_ch(0, 16'sd1000, 8'h10, 2'b11);
    repeat (PER - 4) tick();
    chk("snapshot_left", left, 1000);

    // Mute fade-out then symmetric fade-in.
    mute = 1'b1;
    for (int n = 1; n <= 257; n++) begin
      do_sample();
      if (n == 1)   chk("fadeout_s1", left, 1000);
      if (n == 129) chk("fadeout_s129", left, 500);
      if (n == 257) chk("fadeout_s257", right, 0);
    end
    mute = 1'b0;
    for (int n = 1; n <= 257; n++) begin
      do_sample();
      if (n == 1)   chk("fadeup_s1", left, 0);
      if (n == 129) chk("fadeup_s129", left, 500);
      if (n == 257) chk("fadeup_s257", right, 1000);
    end

    // Asynchronous reset during accumulation.
    cen = 1'b1;
    tick();
    cen = 1'b0;
    tick();
    #2 RESET96 = 1'b1;
    #1;
    chk("midrst_left", left, 0);
    chk("midrst_right", right, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sample", sample, 0);
    repeat (3) tick();
    RESET96 = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      cnt += int'(sample);
    end
    chk("midrst_nopulse", cnt, 0);
    do_sample();
    chk("postrst_s1", left, 0);
    do_sample();
    chk("postrst_s2", left, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
